// File: rtl/upe_negate_arb.sv
// rtl/upe_negate_arb.sv - two-requester arbiter and one-entry result buffer around a shared 32-bit negator
// Optional feature macro: UPE_NEGATE_ARB_RR_EN (round-robin grant; fixed priority when undefined)

// Combinational two's-complement negator, (~a + 1) mod 2^32.
module upe_negate32u (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = ~a + 32'd1;
endmodule

module upe_negate_arb #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [31:0]          req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [31:0]          req1_data,
  output logic                 req1_ready,
  output logic                 res_valid,
  output logic [31:0]          res_data,
  output logic                 res_id,
  output logic                 res_ovf,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] res_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state;
  logic        last_grant;
  logic        grant;
  logic        slot_free;
  logic        accept;
  logic        drain;
  logic [31:0] sel_data;
  logic [31:0] neg_data;

  assign res_valid = (state == ST_FULL);
  assign slot_free = (state == ST_EMPTY) || res_ready;
  assign drain     = (state == ST_FULL) && res_ready;

  // Pick the requester that owns the negator this cycle.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef UPE_NEGATE_ARB_RR_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readies are held low during reset so nothing is accepted into a buffer being cleared.
  assign req0_ready = !reset && slot_free && !grant && req0_valid;
  assign req1_ready = !reset && slot_free &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  assign sel_data = grant ? req1_data : req0_data;

  upe_negate32u u_neg (
    .a (sel_data),
    .y (neg_data)
  );

  // Buffer state, payload, grant history and drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      res_data   <= 32'd0;
      res_id     <= 1'b0;
      res_ovf    <= 1'b0;
      res_count  <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        state    <= ST_FULL;
        res_data <= neg_data;
        res_id   <= grant;
        res_ovf  <= (sel_data == 32'h8000_0000);
      end else if (drain) begin
        state <= ST_EMPTY;
      end
      last_grant <= accept ? grant : last_grant;
      if (drain) begin
        res_count <= res_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_upe_negate_arb.sv
// tb/tb_upe_negate_arb.sv - scoreboard testbench for upe_negate_arb
module tb_upe_negate_arb;

`ifdef UPE_NEGATE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_id, res_ovf;
  logic        res_ready;
  logic [15:0] res_count;

  upe_negate_arb #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ovf    (res_ovf),
    .res_ready  (res_ready),
    .res_count  (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected results in flight: {data, id, ovf}
  logic [33:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model of the request side: predicts readies and pushes expected results.
  bit m_full = 1'b0;
  bit m_last = 1'b1;
  always @(negedge clk) begin
    bit          free, win, e0, e1;
    logic [31:0] d, n;
    #1;
    if (reset) begin
      chk("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
      chk("ready1_in_reset", {31'd0, req1_ready}, 32'd0);
      q.delete();
      m_full = 1'b0;
      m_last = 1'b1;
    end else begin
      free = !m_full || res_ready;
      if (req0_valid && req1_valid) win = RR ? !m_last : 1'b0;
      else                          win = req1_valid;
      e0 = free && req0_valid && !win;
      e1 = free && req1_valid &&  win;
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      if (e0 || e1) begin
        d = win ? req1_data : req0_data;
        n = 32'd0 - d;
        q.push_back({n, win, (n == d) && (d != 32'd0)});
        m_last = win;
        m_full = 1'b1;
      end else if (m_full && res_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares presented results against the scoreboard and tracks the drain count.
  logic [15:0] exp_cnt = 16'd0;
  always @(negedge clk) begin
    logic [33:0] h;
    if (reset) begin
      exp_cnt = 16'd0;
    end else begin
      chk("res_valid", {31'd0, res_valid}, {31'd0, q.size() > 0});
      chk("res_count", {16'd0, res_count}, {16'd0, exp_cnt});
      if (res_valid && q.size() > 0) begin
        h = q[0];
        chk("res_data", res_data, h[33:2]);
        chk("res_id", {31'd0, res_id}, {31'd0, h[1]});
        chk("res_ovf", {31'd0, res_ovf}, {31'd0, h[0]});
        if (res_ready) begin
          void'(q.pop_front());
          exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 32'd0; req1_data = 32'd0; res_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_data", res_data, 32'd0);
    chk("reset_count", {16'd0, res_count}, 32'd0);
    step();

    // single request
    req0_valid = 1'b1; req0_data = 32'hCB2AEACF; res_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", {31'd0, res_valid}, 32'd1);
    chk("single_data", res_data, 32'h34D51531);
    chk("single_id", {31'd0, res_id}, 32'd0);
    chk("single_ovf", {31'd0, res_ovf}, 32'd0);
    step();
    @(negedge clk);
    chk("single_count", {16'd0, res_count}, 32'd1);
    step();

    // overflow operand and zero operand
    req1_valid = 1'b1; req1_data = 32'h8000_0000;
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("ovf_data", res_data, 32'h8000_0000);
    chk("ovf_flag", {31'd0, res_ovf}, 32'd1);
    chk("ovf_id", {31'd0, res_id}, 32'd1);
    step();
    req0_valid = 1'b1; req0_data = 32'd0;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("zero_data", res_data, 32'd0);
    chk("zero_ovf", {31'd0, res_ovf}, 32'd0);
    step();

    // contention right after reset
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_data = $urandom; req1_data = $urandom;
      step();
      @(negedge clk);
      chk("cont_valid", {31'd0, res_valid}, 32'd1);
      chk("cont_id", {31'd0, res_id}, {31'd0, RR ? i[0] : 1'b0});
    end

    // backpressure while full
    step();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
    end
    res_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_valid", {31'd0, res_valid}, 32'd1);

    // reset while full and draining
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("midreset_valid", {31'd0, res_valid}, 32'd0);
    chk("midreset_count", {16'd0, res_count}, 32'd0);
    step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      case ($urandom_range(0, 7))
        0:       req0_data = 32'h8000_0000;
        1:       req0_data = 32'd0;
        default: req0_data = $urandom;
      endcase
      req1_data = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      res_ready = $urandom_range(0, 3) != 0;
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    // counter wrap after 2^16 drains
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      req0_data = $urandom;
      step();
    end
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    chk("wrap_count", {16'd0, res_count}, 32'd0);
    chk("wrap_valid", {31'd0, res_valid}, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
